checkpoint_tx: RTL and testbench

//  Wishbone-slave status-code transmitter in the management SoC. Firmware writes 16-bit

---
 rtl/checkpoint_tx.sv | 201 ++++++++++++++++++++
 tb/tb_checkpoint_tx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_tx.sv
// checkpoint_tx: Wishbone slave that queues 16-bit firmware checkpoint codes
// and replays each one on mprj_io[31:16] for a programmable hold time,
// followed by a programmable idle gap, so every write is visible on the pins.
module checkpoint_tx #(
   parameter logic [31:0] BASE_ADR  = 32'h2600_0000,
   parameter int          DEPTH     = 8,
   parameter logic [15:0] IDLE_CODE = 16'h0000,
   parameter logic [15:0] DEF_HOLD  = 16'd16,
   parameter logic [7:0]  DEF_GAP   = 8'd4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic [15:0] chk_o,
   output logic [15:0] chk_oeb,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SHOW = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]    state;
   logic [15:0]   cnt;
   logic [15:0]   hold;
   logic [7:0]    gap;
   logic          en;
   logic          ovf;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;
   logic          empty;
   logic          full;

   logic          access;
   logic [1:0]    reg_sel;
   logic          push_req;
   logic          push_ok;
   logic          ctrl_wr;
   logic          stat_wr;
   logic          pop;
   logic [15:0]   head;
   logic [15:0]   load_cnt;
   logic [31:0]   rd_data;
   logic          unused_bits;

   // Select, byte lanes and the low address bits carry no information here.
   assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[30:24]};

   assign reg_sel  = wb_adr_i[3:2];
   assign access   = wb_cyc_i & wb_stb_i & (wb_adr_i[31:4] == BASE_ADR[31:4]) & ~wb_ack_o;
   assign push_req = access & wb_we_i & (reg_sel == 2'd0);
   assign ctrl_wr  = access & wb_we_i & (reg_sel == 2'd1);
   assign stat_wr  = access & wb_we_i & (reg_sel == 2'd2);

   assign empty    = (level == '0);
   assign full     = (level == LEVEL_FULL);
   assign head     = mem[rd_ptr];
   assign load_cnt = (hold == 16'd0) ? 16'd0 : hold - 16'd1;

   // A pop coinciding with a push while full frees the slot first.
   assign push_ok  = push_req & (~full | pop);

   // The sequencer consumes a code from idle, or back-to-back when there is no gap.
   assign pop = ~empty & ((state == ST_IDLE) |
                          ((state == ST_SHOW) & (cnt == 16'd0) & (gap == 8'd0)));

   assign busy    = (state != ST_IDLE) | ~empty;
   assign chk_oeb = en ? 16'h0000 : 16'hFFFF;

   // Register read mux, sampled into wb_dat_o at the acknowledge edge.
   always_comb begin
      rd_data = 32'h0;
      case (reg_sel)
         2'd0: rd_data = {16'h0, (state == ST_SHOW) ? chk_o : IDLE_CODE};
         2'd1: rd_data = {en, 7'h0, gap, hold};
         2'd2: rd_data = {22'h0, ovf, busy, 3'h0, 5'(level)};
         default: rd_data = 32'h0;
      endcase
   end

   // Single-cycle acknowledge; read data is only non-zero while acking a read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= 32'h0;
      end else begin
         wb_ack_o <= access;
         wb_dat_o <= (access & ~wb_we_i) ? rd_data : 32'h0;
      end
   end

   // Control and sticky overflow flag; overflow is cleared by writing 1 to bit 9.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold <= DEF_HOLD;
         gap  <= DEF_GAP;
         en   <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            hold <= wb_dat_i[15:0];
            gap  <= wb_dat_i[23:16];
            en   <= wb_dat_i[31];
         end
         if (push_req & ~push_ok) begin
            ovf <= 1'b1;
         end else if (stat_wr & wb_dat_i[9]) begin
            ovf <= 1'b0;
         end
      end
   end

   // FIFO storage has no reset; validity is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wb_dat_i[15:0];
      end
   end

   // FIFO pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok & ~pop) begin
            level <= level + 1'b1;
         end else if (~push_ok & pop) begin
            level <= level - 1'b1;
         end
      end
   end

   // Show/gap sequencer driving the pins; hold/gap are sampled only when cnt loads.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         cnt   <= 16'd0;
         chk_o <= IDLE_CODE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  state <= ST_SHOW;
                  chk_o <= head;
                  cnt   <= load_cnt;
               end
            end
            ST_SHOW: begin
               if (cnt == 16'd0) begin
                  if (gap != 8'd0) begin
                     state <= ST_GAP;
                     chk_o <= IDLE_CODE;
                     cnt   <= {8'h0, gap} - 16'd1;
                  end else if (!empty) begin
                     chk_o <= head;
                     cnt   <= load_cnt;
                  end else begin
                     state <= ST_IDLE;
                     chk_o <= IDLE_CODE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ST_GAP: begin
               if (cnt == 16'd0) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               chk_o <= IDLE_CODE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_checkpoint_tx.sv
// tb_checkpoint_tx: scoreboard bench for checkpoint_tx. The pin waveform is
// cut into runs of constant value and each run is matched against the runs
// predicted from the written codes, hold and gap settings.
module tb_checkpoint_tx;

   localparam logic [31:0] BASE = 32'h2600_0000;
   localparam logic [15:0] IDLE = 16'h0000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_we_i = 1'b0;
   logic [3:0]  wb_sel_i = 4'hF;
   logic [31:0] wb_adr_i = 32'h0;
   logic [31:0] wb_dat_i = 32'h0;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic [15:0] chk_o;
   logic [15:0] chk_oeb;
   logic        busy;

   checkpoint_tx dut (
      .clk      (clk),
      .resetn   (resetn),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_we_i  (wb_we_i),
      .wb_sel_i (wb_sel_i),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_ack_o (wb_ack_o),
      .wb_dat_o (wb_dat_o),
      .chk_o    (chk_o),
      .chk_oeb  (chk_oeb),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      int          len;
      bit          exact;
   } seg_t;

   seg_t        exp_q[$];
   logic [32:0] rd_q[$];
   logic [15:0] burst_q[$];

   int errors = 0;
   int checks = 0;
   bit model_en = 1'b0;
   int model_hold = 16;
   int model_gap = 4;
   bit had_code = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Compares one finished run of constant pin value against the next prediction.
   task automatic close_seg(input logic [15:0] val, input int len);
      seg_t s;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL seg_unexpected: actual value=0x%0h len=%0d required none", val, len);
      end else begin
         s = exp_q.pop_front();
         check_output("seg_value", {16'h0, val}, {16'h0, s.val});
         checks++;
         if (s.exact ? (len != s.len) : (len < s.len)) begin
            errors++;
            $display("[TB] FAIL seg_len: value=0x%0h actual len=%0d required %s%0d",
                     val, len, s.exact ? "" : ">=", s.len);
         end
      end
   endtask

   // Pin monitor: run-length segments of chk_o plus the output-enable state.
   initial begin : pin_monitor
      logic [15:0] cur;
      int          len;
      bit          started;
      started = 1'b0;
      cur = IDLE;
      len = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            started = 1'b0;
         end else begin
            check_output("chk_oeb", {16'h0, chk_oeb}, model_en ? 32'h0 : 32'hFFFF);
            if (!started) begin
               if (chk_o !== IDLE) begin
                  started = 1'b1;
                  cur = chk_o;
                  len = 1;
               end
            end else if (chk_o === cur) begin
               len++;
            end else begin
               close_seg(cur, len);
               cur = chk_o;
               len = 1;
            end
         end
      end
   end

   // Bus monitor: every acknowledge consumes one expected bus response.
   initial begin : bus_monitor
      logic        ack_d;
      logic [32:0] e;
      ack_d = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            ack_d = 1'b0;
         end else begin
            if (wb_ack_o) begin
               check_output("ack_single", {31'h0, ack_d}, 32'h0);
               if (rd_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL bus_unexpected_ack: actual ack=1 required none");
               end else begin
                  e = rd_q.pop_front();
                  if (e[32]) begin
                     check_output("bus_read", wb_dat_o, e[31:0]);
                  end
               end
            end else begin
               check_output("dat_idle_zero", wb_dat_o, 32'h0);
            end
            ack_d = wb_ack_o;
         end
      end
   end

   task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      int n;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!wb_ack_o && n < 8);
      check_output("bus_ack_timeout", {31'h0, wb_ack_o}, 32'h1);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat);
      rd_q.push_back({1'b0, 32'h0});
      bus_xfer(1'b1, adr, dat);
   endtask

   task automatic bus_read(input logic [31:0] adr, input logic [31:0] expv);
      rd_q.push_back({1'b1, expv});
      bus_xfer(1'b0, adr, 32'h0);
   endtask

   task automatic set_ctrl(input bit e, input int h, input int g);
      bus_write(BASE + 32'h4, {e, 7'h0, 8'(g), 16'(h)});
      model_en = e;
      model_hold = h;
      model_gap = g;
   endtask

   // Predicts the pin runs for burst_q, then writes the codes back to back.
   task automatic apply_stimulus();
      seg_t s;
      int   h;
      h = (model_hold == 0) ? 1 : model_hold;
      foreach (burst_q[i]) begin
         if (i == 0) begin
            if (had_code) exp_q.push_back('{IDLE, 1, 1'b0});
         end else if (model_gap > 0) begin
            exp_q.push_back('{IDLE, model_gap + 1, 1'b1});
         end
         if (i > 0 && model_gap == 0 && exp_q.size() > 0 && exp_q[exp_q.size()-1].val == burst_q[i]) begin
            s = exp_q.pop_back();
            s.len += h;
            exp_q.push_back(s);
         end else begin
            exp_q.push_back('{burst_q[i], h, 1'b1});
         end
         had_code = 1'b1;
         bus_write(BASE, {16'h0, burst_q[i]});
      end
      burst_q.delete();
   endtask

   task automatic wait_quiet(input int budget);
      int n;
      n = 0;
      while ((busy || chk_o !== IDLE) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_output("quiet_timeout", {31'h0, busy}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check_output("sb_drain", exp_q.size(), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check_output("rst_chk_o", {16'h0, chk_o}, {16'h0, IDLE});
      check_output("rst_chk_oeb", {16'h0, chk_oeb}, 32'hFFFF);
      check_output("rst_busy", {31'h0, busy}, 32'h0);
      check_output("rst_ack", {31'h0, wb_ack_o}, 32'h0);
      exp_q.delete();
      rd_q.delete();
      model_en = 1'b0;
      model_hold = 16;
      model_gap = 4;
      had_code = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      int          n;
      logic [15:0] c;
      logic [15:0] prev;

      do_reset();
      bus_read(BASE + 32'h8, 32'h0);
      bus_read(BASE + 32'h4, 32'h0004_0010);
      bus_read(BASE + 32'h0, 32'h0);

      // Single code with hold=3, gap=2, then busy tail length.
      set_ctrl(1'b1, 3, 2);
      burst_q.push_back(16'hA040);
      apply_stimulus();
      n = 0;
      while (chk_o !== 16'hA040 && n < 20) begin @(negedge clk); n++; end
      while (chk_o === 16'hA040 && n < 40) begin @(negedge clk); n++; end
      n = 0;
      while (busy && n < 20) begin n++; @(negedge clk); end
      check_output("busy_tail", n, 32'd2);
      wait_quiet(100);

      // Four-code burst with hold=5, gap=1.
      set_ctrl(1'b1, 5, 1);
      burst_q = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB21};
      apply_stimulus();
      wait_quiet(200);

      // gap=0: identical codes merge into one long level.
      set_ctrl(1'b1, 4, 0);
      burst_q = '{16'hAB11, 16'hAB11};
      apply_stimulus();
      wait_quiet(100);

      // hold=0 shows for one cycle; register readback and unmapped access.
      set_ctrl(1'b0, 0, 1);
      bus_read(BASE + 32'h4, 32'h0001_0000);
      burst_q = '{16'h1111, 16'h2222, 16'h3333};
      apply_stimulus();
      wait_quiet(100);
      bus_read(BASE + 32'hC, 32'h0);
      bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
      bus_read(BASE + 32'h4, 32'h0001_0000);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_adr_i = 32'h2700_0004;
      n = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (wb_ack_o) n++;
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      check_output("foreign_adr_acks", n, 32'd0);

      // Randomised bursts checked against the run predictions.
      for (int r = 0; r < 8; r++) begin
         int h;
         int g;
         int blen;
         h = $urandom_range(0, 6);
         g = $urandom_range(0, 3);
         if (g == 0 && h < 2) h = 2;
         set_ctrl(1'($urandom_range(0, 1)), h, g);
         bus_read(BASE + 32'h4, {model_en, 7'h0, 8'(g), 16'(h)});
         blen = $urandom_range(1, 5);
         prev = IDLE;
         for (int k = 0; k < blen; k++) begin
            c = 16'($urandom_range(1, 65535));
            while (c == prev) c = 16'($urandom_range(1, 65535));
            burst_q.push_back(c);
            prev = c;
         end
         apply_stimulus();
         wait_quiet(300);
         bus_read(BASE + 32'h8, 32'h0);
      end

      // Overflow: long hold, ten writes, eight stay queued, the last is dropped.
      set_ctrl(1'b1, 1000, 0);
      for (int k = 0; k < 10; k++) burst_q.push_back(16'hC000 + 16'(k));
      apply_stimulus();
      bus_read(BASE + 32'h0, 32'h0000_C000);
      bus_read(BASE + 32'h8, 32'h0000_0308);
      bus_write(BASE + 32'h8, 32'h0000_0200);
      bus_read(BASE + 32'h8, 32'h0000_0108);

      // Reset while a code is being shown aborts everything.
      do_reset();
      bus_read(BASE + 32'h8, 32'h0);
      bus_read(BASE + 32'h4, 32'h0004_0010);
      repeat (5) @(negedge clk);
      check_output("post_rst_chk_o", {16'h0, chk_o}, {16'h0, IDLE});
      check_output("bus_q_drain", rd_q.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
